// File: rtl/fantasma_pkg.sv
// Shared definitions for the multi-sprite bounce engine: FSM encoding and
// per-sprite reset placement/direction.
package fantasma_pkg;

    localparam int CW_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWEEP   = 2'd1,
        ST_COLLIDE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int unsigned reset_x(input int unsigned i);
        return 32 + 64 * i;
    endfunction

    function automatic int unsigned reset_y(input int unsigned i);
        return 24 + 48 * i;
    endfunction

    // Direction bit: 1 = moving towards larger coordinates.
    function automatic logic reset_dirx(input int unsigned i);
        return (i % 2) == 0;
    endfunction

    function automatic logic reset_diry(input int unsigned i);
        return (i % 4) < 2;
    endfunction

endpackage

// File: rtl/rebote_multisprite_if.sv
// Sync-side inputs and per-frame sprite state outputs of rebote_multisprite.
interface rebote_multisprite_if
    import fantasma_pkg::*;
#(
    parameter int NSPR = 4,
    parameter int CW   = CW_DEF
);
    logic                 vsync;
    logic                 enable;
    logic [NSPR*CW-1:0]   posx;
    logic [NSPR*CW-1:0]   posy;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          bounce_cnt;
    logic                 overrun;
    logic [NSPR-1:0]      collide;

    modport master (
        output vsync, enable,
        input  posx, posy, busy, frame_done, bounce_cnt, overrun, collide
    );

    modport slave (
        input  vsync, enable,
        output posx, posy, busy, frame_done, bounce_cnt, overrun, collide
    );
endinterface

// File: rtl/rebote_eje.sv
// Combinational single-axis step: advance by SPEED, clamping and reflecting
// at 0 and at limit.
module rebote_eje
#(
    parameter int CW    = 11,
    parameter int SPEED = 1
)
(
    input  logic [CW-1:0] pos,
    input  logic          dir,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] new_pos,
    output logic          new_dir,
    output logic          bounce
);
    localparam logic [CW-1:0] SPD = CW'(SPEED);

    // One extra bit on the forward sum so positions near the top of the
    // coordinate range cannot wrap past the limit test.
    logic [CW:0] fwd;
    assign fwd = {1'b0, pos} + {1'b0, SPD};

    always_comb begin
        new_pos = pos;
        new_dir = dir;
        bounce  = 1'b0;
        if (dir) begin
            if (fwd > {1'b0, limit}) begin
                new_pos = limit;
                new_dir = 1'b0;
                bounce  = 1'b1;
            end else begin
                new_pos = fwd[CW-1:0];
            end
        end else begin
            if (pos < SPD) begin
                new_pos = '0;
                new_dir = 1'b1;
                bounce  = 1'b1;
            end else begin
                new_pos = pos - SPD;
            end
        end
    end
endmodule

// File: rtl/rebote_multisprite.sv
// Per-frame motion engine for NSPR bouncing sprites, one sprite per clock.
// Optional pairwise overlap scan enabled with macro REBOTE_COLLIDE_EN.
module rebote_multisprite
    import fantasma_pkg::*;
#(
    parameter int NSPR   = 4,
    parameter int CW     = CW_DEF,
    parameter int HRES   = 640,
    parameter int VRES   = 480,
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int SPEED  = 1,
    parameter int VS_POL = 0
)
(
    input  logic                 clk,
    input  logic                 rst,
    rebote_multisprite_if.slave  bus
);
    localparam int              IW     = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam logic [IW-1:0]   LAST   = IW'(NSPR - 1);
    localparam logic            VS_ACT = (VS_POL != 0);
    localparam logic [CW-1:0]   XLIM   = CW'(HRES - SPR_W);
    localparam logic [CW-1:0]   YLIM   = CW'(VRES - SPR_H);
`ifdef REBOTE_COLLIDE_EN
    localparam bit              HAS_COL = (NSPR > 1);
`else
    localparam bit              HAS_COL = 1'b0;
`endif

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t          state, nxt;
    logic            vs_p0, start_p1;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   xs [NSPR];
    logic [CW-1:0]   ys [NSPR];
    logic [NSPR-1:0] dxs, dys;
    logic [15:0]     bcnt;
    logic            ovr;
    logic [CW-1:0]   nx, ny;
    logic            ndx, ndy, bx, by;
    logic            sweep_start, sweep_last, pair_last;
    logic [NSPR-1:0] col_w;

    rebote_eje #(.CW(CW), .SPEED(SPEED)) u_eje_x (
        .pos(xs[idx]), .dir(dxs[idx]), .limit(XLIM),
        .new_pos(nx), .new_dir(ndx), .bounce(bx)
    );

    rebote_eje #(.CW(CW), .SPEED(SPEED)) u_eje_y (
        .pos(ys[idx]), .dir(dys[idx]), .limit(YLIM),
        .new_pos(ny), .new_dir(ndy), .bounce(by)
    );

    // Stage p0/p1: vsync history and registered frame-start strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_p0    <= ~VS_ACT;
            start_p1 <= 1'b0;
        end else begin
            vs_p0    <= bus.vsync;
            start_p1 <= (bus.vsync == VS_ACT) && (vs_p0 != VS_ACT);
        end
    end

    assign sweep_start = (state == ST_IDLE) && start_p1 && bus.enable;
    assign sweep_last  = (state == ST_SWEEP) && (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (sweep_start) nxt = ST_SWEEP;
            ST_SWEEP:   if (idx == LAST) nxt = HAS_COL ? ST_COLLIDE : ST_DONE;
            ST_COLLIDE: if (pair_last) nxt = ST_DONE;
            ST_DONE:    nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Sweep datapath: one sprite written back per SWEEP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSPR; i++) begin
                xs[i]  <= CW'(reset_x(i));
                ys[i]  <= CW'(reset_y(i));
                dxs[i] <= reset_dirx(i);
                dys[i] <= reset_diry(i);
            end
            idx  <= '0;
            bcnt <= '0;
            ovr  <= 1'b0;
        end else begin
            if (sweep_start) begin
                idx <= '0;
            end else if (state == ST_SWEEP) begin
                xs[idx]  <= nx;
                ys[idx]  <= ny;
                dxs[idx] <= ndx;
                dys[idx] <= ndy;
                bcnt     <= sat_add(bcnt, {1'b0, bx} + {1'b0, by});
                idx      <= idx + 1'b1;
            end
            if (start_p1 && (state != ST_IDLE)) ovr <= 1'b1;
        end
    end

`ifdef REBOTE_COLLIDE_EN
    logic [IW-1:0]   pa, pb;
    logic [NSPR-1:0] col_r;
    logic [CW-1:0]   ddx, ddy;
    logic            pair_hit;

    assign pair_last = (pa == IW'(NSPR - 2)) && (pb == LAST);

    always_comb begin
        ddx      = (xs[pa] >= xs[pb]) ? xs[pa] - xs[pb] : xs[pb] - xs[pa];
        ddy      = (ys[pa] >= ys[pb]) ? ys[pa] - ys[pb] : ys[pb] - ys[pa];
        pair_hit = (ddx < CW'(SPR_W)) && (ddy < CW'(SPR_H));
    end

    // Stage: pair scan (a<b) over the just-updated positions
    always_ff @(posedge clk) begin
        if (rst) begin
            pa    <= '0;
            pb    <= '0;
            col_r <= '0;
        end else begin
            if (sweep_start) col_r <= '0;
            if (sweep_last) begin
                pa <= '0;
                pb <= IW'(1);
            end else if (state == ST_COLLIDE) begin
                if (pair_hit) begin
                    col_r[pa] <= 1'b1;
                    col_r[pb] <= 1'b1;
                end
                if (pb == LAST) begin
                    pa <= pa + IW'(1);
                    pb <= pa + IW'(2);
                end else begin
                    pb <= pb + IW'(1);
                end
            end
        end
    end

    assign col_w = col_r;
`else
    assign pair_last = 1'b1;
    assign col_w     = '0;
`endif

    logic [NSPR*CW-1:0] posx_w, posy_w;

    always_comb begin
        posx_w = '0;
        posy_w = '0;
        for (int i = 0; i < NSPR; i++) begin
            posx_w[i*CW +: CW] = xs[i];
            posy_w[i*CW +: CW] = ys[i];
        end
    end

    assign bus.posx       = posx_w;
    assign bus.posy       = posy_w;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = (state == ST_DONE);
    assign bus.bounce_cnt = bcnt;
    assign bus.overrun    = ovr;
    assign bus.collide    = col_w;

endmodule

// File: tb/tb_rebote_multisprite.sv
// Bench for rebote_multisprite: random frame sequence against a per-sprite
// bounce model, plus overrun, disabled-frame and mid-sweep reset steps.
module tb_rebote_multisprite;
    localparam int NSPR  = 4;
    localparam int CW    = 11;
    localparam int HRES  = 640;
    localparam int VRES  = 480;
    localparam int SW    = 16;
    localparam int SH    = 16;
    localparam int SPEED = 1;
`ifdef REBOTE_COLLIDE_EN
    localparam int PAIRS = NSPR * (NSPR - 1) / 2;
`else
    localparam int PAIRS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    rebote_multisprite_if #(.NSPR(NSPR), .CW(CW)) bus ();

    rebote_multisprite #(
        .NSPR(NSPR), .CW(CW), .HRES(HRES), .VRES(VRES), .SPR_W(SW), .SPR_H(SH),
        .SPEED(SPEED), .VS_POL(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int mx [NSPR];
    int my [NSPR];
    int mdx[NSPR];
    int mdy[NSPR];
    int mb;
    int movr;
    int nchk = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSPR; i++) begin
            mx[i]  = 32 + 64 * i;
            my[i]  = 24 + 48 * i;
            mdx[i] = (i % 2 == 0) ? 1 : -1;
            mdy[i] = (i % 4 < 2) ? 1 : -1;
        end
        mb   = 0;
        movr = 0;
    endtask

    task automatic axis(inout int p, inout int d, input int lim);
        int t;
        t = p + d * SPEED;
        if (t > lim) begin
            p = lim; d = -1; mb = (mb >= 65535) ? 65535 : mb + 1;
        end else if (t < 0) begin
            p = 0; d = 1; mb = (mb >= 65535) ? 65535 : mb + 1;
        end else begin
            p = t;
        end
    endtask

    task automatic model_frame();
        for (int i = 0; i < NSPR; i++) begin
            axis(mx[i], mdx[i], HRES - SW);
            axis(my[i], mdy[i], VRES - SH);
        end
    endtask

    function automatic logic [NSPR-1:0] exp_collide();
        logic [NSPR-1:0] c;
        c = '0;
`ifdef REBOTE_COLLIDE_EN
        for (int a = 0; a < NSPR; a++)
            for (int b = a + 1; b < NSPR; b++)
                if ((mx[a] - mx[b] < SW) && (mx[b] - mx[a] < SW) &&
                    (my[a] - my[b] < SH) && (my[b] - my[a] < SH)) begin
                    c[a] = 1'b1;
                    c[b] = 1'b1;
                end
`endif
        return c;
    endfunction

    task automatic check_state(input string ctx);
        for (int i = 0; i < NSPR; i++) begin
            chk($sformatf("%s posx%0d", ctx, i), 64'(bus.posx[i*CW +: CW]), 64'(mx[i]));
            chk($sformatf("%s posy%0d", ctx, i), 64'(bus.posy[i*CW +: CW]), 64'(my[i]));
        end
        chk({ctx, " bounce_cnt"}, 64'(bus.bounce_cnt), 64'(mb));
        chk({ctx, " overrun"}, 64'(bus.overrun), 64'(movr));
        chk({ctx, " collide"}, 64'(bus.collide), 64'(exp_collide()));
    endtask

    // Issue one vsync falling edge and observe the whole sweep window.
    task automatic frame(input bit en, input bit drop_mid);
        int nb, nfd, fd_at;
        nb = 0; nfd = 0; fd_at = 0;
        @(negedge clk);
        bus.enable = en;
        bus.vsync  = 1'b0;
        if (en) model_frame();
        for (int c = 1; c <= NSPR + PAIRS + 6; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) nb++;
            if (bus.frame_done === 1'b1) begin
                nfd++;
                if (fd_at == 0) fd_at = c;
            end
            if (c == 1) bus.vsync = 1'b1;
            if (c == 3 && drop_mid) bus.enable = 1'b0;
        end
        if (en) begin
            chk("frame_done latency", 64'(fd_at), 64'(NSPR + PAIRS + 2));
            chk("busy cycles", 64'(nb), 64'(NSPR + PAIRS + 1));
            chk("frame_done pulses", 64'(nfd), 64'd1);
        end else begin
            chk("disabled busy cycles", 64'(nb), 64'd0);
            chk("disabled frame_done", 64'(nfd), 64'd0);
        end
        check_state(en ? "frame" : "frozen");
    endtask

    initial begin
        int nfd, nb;
        rst = 1'b1;
        bus.vsync  = 1'b1;
        bus.enable = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset frame_done", 64'(bus.frame_done), 64'd0);
        check_state("reset");

        // First frame: sprite0 -> (33,25), sprite1 -> (95,73)
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);

        for (int f = 0; f < 1300; f++) begin
            bit en;
            en = ($urandom_range(0, 9) != 0);
            frame(en, en && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Two vsync edges two cycles apart: one sweep, overrun latches
        @(negedge clk);
        bus.enable = 1'b1;
        bus.vsync  = 1'b0;
        @(negedge clk); bus.vsync = 1'b1;
        @(negedge clk); bus.vsync = 1'b0;
        @(negedge clk); bus.vsync = 1'b1;
        model_frame();
        movr = 1;
        nfd = 0;
        for (int c = 0; c < NSPR + PAIRS + 8; c++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) nfd++;
        end
        chk("overrun single sweep", 64'(nfd), 64'd1);
        check_state("overrun");
        frame(1'b1, 1'b0);

        // Reset in the middle of a sweep
        @(negedge clk);
        bus.enable = 1'b1;
        bus.vsync  = 1'b0;
        @(negedge clk); bus.vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid-sweep busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        nfd = 0; nb = 0;
        for (int c = 0; c < NSPR + PAIRS + 6; c++) begin
            if (bus.frame_done === 1'b1) nfd++;
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
        end
        chk("post-reset frame_done", 64'(nfd), 64'd0);
        chk("post-reset busy", 64'(nb), 64'd0);
        check_state("post-reset");
        frame(1'b1, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
